rf_wb_queue: RTL

- Write-back queue that owns the register file's single write port.
- Accepts execution results over a valid/ready handshake and buffers them in a DEPTH-entry in-order FIFO.
- Drains at most one entry per cycle into registered wr_en/dst/datain outputs that feed the register file directly.
- Provides per-read-port forwarding of pending, not-yet-committed values, so operand reads see the newest architectural value.

---
 rtl/rf_wb_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order write-back FIFO that owns the register-file write port
// and forwards pending, not-yet-committed values to each read port.
module rf_wb_queue #(
  parameter int DATA_W     = 32,
  parameter int ADRS_W     = 4,
  parameter int READ_PORTS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  res_valid,
  output logic                                  res_ready,
  input  logic [ADRS_W-1:0]                     res_dst,
  input  logic [DATA_W-1:0]                     res_data,
  input  logic                                  wb_hold,
  output logic                                  wr_en,
  output logic [ADRS_W-1:0]                     dst,
  output logic [DATA_W-1:0]                     datain,
  input  logic [READ_PORTS-1:0][ADRS_W-1:0]     fwd_src,
  output logic [READ_PORTS-1:0]                 fwd_hit,
  output logic [READ_PORTS-1:0][DATA_W-1:0]     fwd_data,
  output logic [$clog2(DEPTH):0]                count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADRS_W-1:0] mem_dst  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     slot     [DEPTH];
  logic              push;
  logic              pop;

  assign res_ready = (count != CW'(DEPTH));
  assign push      = res_valid && res_ready;
  assign pop       = (count != '0) && !wb_hold;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_dst[wr_ptr]  <= res_dst;
      mem_data[wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_en  <= 1'b0;
      dst    <= '0;
      datain <= '0;
    end else begin
      wr_en <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        dst    <= mem_dst[rd_ptr];
        datain <= mem_data[rd_ptr];
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // slot[k] is the k-th oldest entry; later matches override earlier ones
  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot[k] = rd_ptr + PW'(k);
  end

  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (wr_en && dst == fwd_src[i]) begin
        fwd_hit[i]  = 1'b1;
        fwd_data[i] = datain;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count && mem_dst[slot[k]] == fwd_src[i]) begin
          fwd_hit[i]  = 1'b1;
          fwd_data[i] = mem_data[slot[k]];
        end
      end
    end
  end

endmodule
